// File: rtl/spi_slave_phy.sv
// SPI mode-0 slave PHY, fully in the clk domain: the pad signals are synchronized
// and edge-detected, then they feed the RX shifter with a 1-deep output register and the TX holding buffer.
module spi_slave_phy #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       spi_clk,
   input  logic       spi_mosi,
   input  logic       spi_ss,
   output logic       spi_miso,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       rx_overflow,
   output logic       busy
);

   logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ss_sync;
   logic       sck_d, ss_d;
   logic       sck_s, mosi_s, ss_s, ss_act;
   logic       sck_rise, sck_fall, ss_fall, ss_rise;
   logic [6:0] rx_shift;
   logic [2:0] bit_cnt;
   logic       byte_done;
   logic [7:0] rx_byte;
   logic [7:0] tx_buf, tx_shift;
   logic       tx_full, load_pend, load_ev;

   // All three inputs use the same depth, so MOSI stays aligned with its SCK edge
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sck_sync  <= '0;
         mosi_sync <= '0;
         ss_sync   <= '1;
         sck_d     <= 1'b0;
         ss_d      <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
         sck_d     <= sck_s;
         ss_d      <= ss_s;
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign ss_s     = ss_sync[SYNC_STAGES-1];
   assign ss_act   = ~ss_s;
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign ss_fall  = ~ss_s & ss_d;
   assign ss_rise  = ss_s & ~ss_d;

   assign byte_done = sck_rise & ss_act & (bit_cnt == 3'd7);
   assign rx_byte   = {rx_shift, mosi_s};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_shift    <= '0;
         bit_cnt     <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         rx_overflow <= 1'b0;
      end else begin
         if (ss_rise) begin
            rx_shift <= '0;
            bit_cnt  <= '0;
         end else if (sck_rise && ss_act) begin
            rx_shift <= {rx_shift[5:0], mosi_s};
            bit_cnt  <= bit_cnt + 3'd1;
         end
         // A consumer handshake in the completion cycle frees the slot for the new byte
         if (byte_done) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= rx_byte;
               rx_valid <= 1'b1;
            end else begin
               rx_overflow <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   // Next byte is loaded at SS fall, or on the first SCK fall following a completed byte
   assign load_ev = ss_fall | (sck_fall & ss_act & load_pend);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tx_buf    <= '0;
         tx_full   <= 1'b0;
         tx_shift  <= 8'hFF;
         load_pend <= 1'b0;
      end else begin
         if (ss_rise) begin
            tx_shift  <= 8'hFF;
            load_pend <= 1'b0;
         end else if (load_ev) begin
            tx_shift  <= tx_full ? tx_buf : 8'hFF;
            load_pend <= 1'b0;
         end else begin
            if (sck_fall && ss_act) tx_shift <= {tx_shift[6:0], 1'b1};
            if (byte_done) load_pend <= 1'b1;
         end
         // A write can only land in an empty buffer, so a coincident load sees the old (empty) state
         if (tx_valid && !tx_full) begin
            tx_buf  <= tx_data;
            tx_full <= 1'b1;
         end else if (load_ev) begin
            tx_full <= 1'b0;
         end
      end
   end

   assign tx_ready = ~tx_full;
   assign busy     = ss_act;
   assign spi_miso = ss_act ? tx_shift[7] : 1'b1;

endmodule

// File: tb/tb_spi_slave_phy.sv
// Bench for spi_slave_phy: bit-banged SPI master, RX scoreboard checked by a
// handshake monitor, MISO bytes compared against the expected TX byte per frame.
module tb_spi_slave_phy;

   localparam int SS = 2;

   logic       clk, rstn;
   logic       spi_clk, spi_mosi, spi_ss, spi_miso;
   logic [7:0] rx_data, tx_data;
   logic       rx_valid, rx_ready, tx_valid, tx_ready, rx_overflow, busy;

   spi_slave_phy #(.SYNC_STAGES(SS)) dut (
      .clk(clk), .rstn(rstn),
      .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_ss(spi_ss), .spi_miso(spi_miso),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_overflow(rx_overflow), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_e;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   // Monitor: every accepted RX byte must be the oldest byte the master sent
   always @(negedge clk) begin
      if (rstn && rx_valid && rx_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rx_unexpected: got %02h expected none", rx_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("rx_data", rx_data, mon_e);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clkw(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Master sends nbits MSB-first; MISO is sampled just before each rising SCK
   task automatic xfer(input logic [7:0] mo, input int nbits, input bit pulse,
                       output logic [7:0] mi);
      mi = 8'hFF;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_mosi = mo[i];
         clkw(5);
         mi[i] = spi_miso;
         spi_clk = 1'b1;
         if (pulse && i == 0) begin
            clkw(SS);
            rx_ready = 1'b1;
            clkw(1);
            rx_ready = 1'b0;
            clkw(5 - SS - 1);
         end else begin
            clkw(5);
         end
         spi_clk = 1'b0;
      end
   endtask

   task automatic frame_start();
      spi_ss = 1'b0;
      clkw(SS + 4);
   endtask

   task automatic frame_end();
      clkw(5);
      spi_ss = 1'b1;
      clkw(SS + 6);
   endtask

   task automatic tx_write(input logic [7:0] d);
      int n = 0;
      while (!tx_ready && n < 100) begin
         clkw(1);
         n++;
      end
      if (!tx_ready) begin
         tests++;
         fails++;
         $display("FAIL tx_ready_timeout: got 0 expected 1");
      end else begin
         tx_data  = d;
         tx_valid = 1'b1;
         clkw(1);
         tx_valid = 1'b0;
      end
   endtask

   logic [7:0] mi, d, t;
   int nb, plen;
   bit part, pre;

   initial begin
      rstn = 1'b0; spi_clk = 1'b0; spi_mosi = 1'b0; spi_ss = 1'b1;
      rx_ready = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
      clkw(2);
      check("rst_miso", 8'(spi_miso), 8'd1);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_valid", 8'(rx_valid), 8'd0);
      check("rst_tx_ready", 8'(tx_ready), 8'd1);
      check("rst_overflow", 8'(rx_overflow), 8'd0);
      check("rst_busy", 8'(busy), 8'd0);
      rstn = 1'b1;
      clkw(4);

      // Preloaded TX byte goes out while RX byte comes in
      tx_write(8'h3C);
      frame_start();
      check("busy_in_frame", 8'(busy), 8'd1);
      exp_q.push_back(8'hA5);
      xfer(8'hA5, 8, 1'b0, mi);
      check("miso_3c", mi, 8'h3C);
      frame_end();

      // TX underrun reads 0xFF
      frame_start();
      exp_q.push_back(8'h77);
      xfer(8'h77, 8, 1'b0, mi);
      check("miso_underrun", mi, 8'hFF);
      check("tx_ready_idle", 8'(tx_ready), 8'd1);
      frame_end();

      // Partial frame is discarded, next full frame is clean
      frame_start();
      xfer(8'hFF, 5, 1'b0, mi);
      frame_end();
      check("partial_no_valid", 8'(rx_valid), 8'd0);
      frame_start();
      exp_q.push_back(8'h5A);
      xfer(8'h5A, 8, 1'b0, mi);
      frame_end();

      // Random frames: 1-2 bytes, optional preload, occasional truncated last byte
      for (int f = 0; f < 20; f++) begin
         nb   = $urandom_range(1, 2);
         part = ($urandom_range(0, 3) == 0);
         pre  = $urandom_range(0, 1);
         t    = 8'($urandom);
         if (pre) tx_write(t);
         frame_start();
         for (int k = 0; k < nb; k++) begin
            d = 8'($urandom);
            if (part && k == nb - 1) begin
               plen = $urandom_range(1, 7);
               xfer(d, plen, 1'b0, mi);
            end else begin
               exp_q.push_back(d);
               xfer(d, 8, 1'b0, mi);
               check("miso_rand", mi, (k == 0 && pre) ? t : 8'hFF);
            end
         end
         frame_end();
      end

      // Overflow: second byte dropped while the first is unconsumed
      rx_ready = 1'b0;
      frame_start();
      exp_q.push_back(8'h01);
      xfer(8'h01, 8, 1'b0, mi);
      xfer(8'h02, 8, 1'b0, mi);
      frame_end();
      check("ovf_rx_data", rx_data, 8'h01);
      check("ovf_flag", 8'(rx_overflow), 8'd1);
      check("ovf_rx_valid", 8'(rx_valid), 8'd1);
      rx_ready = 1'b1;
      clkw(3);

      // Asynchronous reset mid-byte with a full TX buffer
      frame_start();
      xfer(8'h96, 4, 1'b0, mi);
      tx_write(8'h11);
      check("tx_ready_full", 8'(tx_ready), 8'd0);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      check("arst_miso", 8'(spi_miso), 8'd1);
      check("arst_rx_data", rx_data, 8'h00);
      check("arst_rx_valid", 8'(rx_valid), 8'd0);
      check("arst_tx_ready", 8'(tx_ready), 8'd1);
      check("arst_overflow", 8'(rx_overflow), 8'd0);
      check("arst_busy", 8'(busy), 8'd0);
      spi_ss = 1'b1;
      clkw(3);
      rstn = 1'b1;
      clkw(5);
      frame_start();
      exp_q.push_back(8'hC3);
      xfer(8'hC3, 8, 1'b0, mi);
      check("miso_after_rst", mi, 8'hFF);
      frame_end();

      // Consumer ready exactly in the completion cycle of the second byte
      rx_ready = 1'b0;
      frame_start();
      exp_q.push_back(8'h21);
      exp_q.push_back(8'h42);
      xfer(8'h21, 8, 1'b0, mi);
      xfer(8'h42, 8, 1'b1, mi);
      frame_end();
      check("coincide_no_ovf", 8'(rx_overflow), 8'd0);
      check("coincide_rx_data", rx_data, 8'h42);
      check("coincide_rx_valid", 8'(rx_valid), 8'd1);
      rx_ready = 1'b1;
      clkw(20);
      check("sb_empty", 8'(exp_q.size()), 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
